// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci result collector slice.
package fib_pkg;

  localparam int unsigned DEPTH_DEFAULT = 8;

  localparam logic signed [63:0] INDEX_NONE = -64'sd1;

  typedef struct packed {
    logic        [63:0] number;
    logic signed [63:0] index;
    logic               is_fib;
  } fib_rec_t;

  function automatic fib_rec_t make_rec(input logic [63:0] num, input logic signed [63:0] idx);
    fib_rec_t rec;
    rec.number = num;
    rec.index  = idx;
    rec.is_fib = (idx != INDEX_NONE);
    return rec;
  endfunction

endpackage

// File: rtl/fib_fifo.sv
// Result FIFO with a registered head: a record pushed into an empty FIFO is
// presented on the head one cycle after the push.
module fib_fifo
  import fib_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  fib_rec_t                   i_push_data,
  input  logic                       i_pop,
  output fib_rec_t                   o_head,
  output logic                       o_valid,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fib_rec_t      r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  fib_rec_t      r_head;
  logic          r_valid;

  logic          w_pop_ok;
  logic          w_push_ok;
  logic [AW-1:0] w_rd_ptr_n;
  logic [CW-1:0] w_count_n;
  fib_rec_t      w_head_n;

  always_comb begin
    w_pop_ok   = i_pop && (r_count != '0);
    w_push_ok  = i_push && ((r_count != CW'(DEPTH)) || w_pop_ok);
    w_rd_ptr_n = r_rd_ptr + AW'(w_pop_ok);
    w_count_n  = r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    // A record entering a FIFO that is empty after this cycle's pop bypasses storage to the head.
    if (w_push_ok && ((r_count - CW'(w_pop_ok)) == '0)) begin
      w_head_n = i_push_data;
    end else begin
      w_head_n = r_mem[w_rd_ptr_n];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_ptr_n;
      r_count  <= w_count_n;
      r_head   <= w_head_n;
      r_valid  <= (w_count_n != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_head  = r_head;
  assign o_valid = r_valid;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/fib_result_collector.sv
// Pairs snooped finder requests with their index strobes, queues the resulting
// records and keeps push/fib/drop statistics plus an orphan-strobe flag.
module fib_result_collector
  import fib_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [63:0]        num_in,
  input  logic               num_valid,
  input  logic               num_ready,
  input  logic signed [63:0] index,
  input  logic               index_valid,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [63:0]        out_number,
  output logic signed [63:0] out_index,
  output logic               out_is_fib,
  input  logic               clr,
  output logic [31:0]        cnt_results,
  output logic [31:0]        cnt_fib,
  output logic [15:0]        cnt_drop,
  output logic               err_orphan
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [63:0]   r_pend_num;
  logic          r_pend_vld;
  logic [31:0]   r_cnt_results;
  logic [31:0]   r_cnt_fib;
  logic [15:0]   r_cnt_drop;
  logic          r_err_orphan;

  logic          w_accept;
  logic          w_pair;
  logic          w_orphan;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_drop;
  fib_rec_t      w_rec;
  fib_rec_t      w_head;
  logic          w_valid;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;

  always_comb begin
    w_accept  = num_valid && num_ready;
    w_pair    = index_valid && r_pend_vld;
    w_orphan  = index_valid && !r_pend_vld;
    w_pop     = !w_empty && out_ready;
    w_push_ok = w_pair && (!w_full || w_pop);
    w_drop    = w_pair && w_full && !w_pop;
    w_rec     = make_rec(r_pend_num, index);
  end

  fib_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push_ok),
    .i_push_data(w_rec),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_valid    (w_valid),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  // A request accepted on the pairing cycle replaces the one being consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_num <= '0;
      r_pend_vld <= 1'b0;
    end else if (w_accept) begin
      r_pend_num <= num_in;
      r_pend_vld <= 1'b1;
    end else if (w_pair) begin
      r_pend_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_results <= '0;
      r_cnt_fib     <= '0;
      r_cnt_drop    <= '0;
      r_err_orphan  <= 1'b0;
    end else if (clr) begin
      r_cnt_results <= '0;
      r_cnt_fib     <= '0;
      r_cnt_drop    <= '0;
      r_err_orphan  <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_cnt_results <= r_cnt_results + 32'd1;
        if (w_rec.is_fib) begin
          r_cnt_fib <= r_cnt_fib + 32'd1;
        end
      end
      if (w_drop && (r_cnt_drop != '1)) begin
        r_cnt_drop <= r_cnt_drop + 16'd1;
      end
      if (w_orphan) begin
        r_err_orphan <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (w_count <= CW'(DEPTH));
    end
  end

  assign out_valid   = w_valid;
  assign out_number  = w_head.number;
  assign out_index   = w_head.index;
  assign out_is_fib  = w_head.is_fib;
  assign cnt_results = r_cnt_results;
  assign cnt_fib     = r_cnt_fib;
  assign cnt_drop    = r_cnt_drop;
  assign err_orphan  = r_err_orphan;

endmodule

// File: tb/tb_fib_result_collector.sv
// Self-checking bench for fib_result_collector: directed table, corner sequences, random vs queue model.
module tb_fib_result_collector;

  localparam int unsigned DEPTH = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [63:0]        num_in;
  logic               num_valid;
  logic               num_ready;
  logic signed [63:0] index;
  logic               index_valid;
  logic               out_valid;
  logic               out_ready;
  logic [63:0]        out_number;
  logic signed [63:0] out_index;
  logic               out_is_fib;
  logic               clr;
  logic [31:0]        cnt_results;
  logic [31:0]        cnt_fib;
  logic [15:0]        cnt_drop;
  logic               err_orphan;

  always #5 clk = ~clk;

  fib_result_collector #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .num_in(num_in), .num_valid(num_valid), .num_ready(num_ready),
    .index(index), .index_valid(index_valid), .out_valid(out_valid), .out_ready(out_ready),
    .out_number(out_number), .out_index(out_index), .out_is_fib(out_is_fib), .clr(clr),
    .cnt_results(cnt_results), .cnt_fib(cnt_fib), .cnt_drop(cnt_drop), .err_orphan(err_orphan)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    num_valid = 0; num_ready = 0; num_in = '0; index_valid = 0; index = '0; clr = 0;
  endtask

  // Reference model: ordered queue of records plus plain counters.
  typedef struct {
    logic [63:0] n;
    logic [63:0] i;
    logic        f;
  } mrec_t;

  mrec_t       q[$];
  logic [63:0] m_pend_num;
  bit          m_pend_vld;
  logic [31:0] m_cr, m_cf;
  logic [15:0] m_cd;
  bit          m_err;

  task automatic model_reset();
    q.delete();
    m_pend_num = '0; m_pend_vld = 0;
    m_cr = '0; m_cf = '0; m_cd = '0; m_err = 0;
  endtask

  task automatic model_step();
    bit    pop, pair, acc;
    mrec_t r;
    pop  = (q.size() != 0) && out_ready;
    pair = index_valid && m_pend_vld;
    acc  = num_valid && num_ready;
    if (pop) void'(q.pop_front());
    if (pair) begin
      r.n = m_pend_num; r.i = index; r.f = (index != -64'sd1);
      if (q.size() < DEPTH) begin
        q.push_back(r);
        m_cr = m_cr + 1;
        if (r.f) m_cf = m_cf + 1;
      end else if (m_cd != 16'hFFFF) begin
        m_cd = m_cd + 1;
      end
    end
    if (index_valid && !m_pend_vld) m_err = 1;
    if (clr) begin
      m_cr = '0; m_cf = '0; m_cd = '0; m_err = 0;
    end
    if (acc) begin
      m_pend_num = num_in; m_pend_vld = 1;
    end else if (pair) begin
      m_pend_vld = 0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk({tag, ".out_number"}, out_number, q[0].n);
      chk({tag, ".out_index"}, out_index, q[0].i);
      chk({tag, ".out_is_fib"}, 64'(out_is_fib), 64'(q[0].f));
    end
    chk({tag, ".cnt_results"}, 64'(cnt_results), 64'(m_cr));
    chk({tag, ".cnt_fib"}, 64'(cnt_fib), 64'(m_cf));
    chk({tag, ".cnt_drop"}, 64'(cnt_drop), 64'(m_cd));
    chk({tag, ".err_orphan"}, 64'(err_orphan), 64'(m_err));
  endtask

  task automatic cycle(input string tag);
    model_step();
    tick();
    check_model(tag);
  endtask

  task automatic do_reset();
    idle();
    out_ready = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
    model_reset();
  endtask

  task automatic req(input logic [63:0] n);
    idle(); num_valid = 1; num_ready = 1; num_in = n;
  endtask

  task automatic strobe(input logic signed [63:0] i);
    idle(); index_valid = 1; index = i;
  endtask

  typedef struct {
    bit          nv, nr;
    logic [63:0] num;
    bit          iv;
    logic [63:0] idx;
    bit          ordy, cl;
    bit          ev;
    logic [63:0] en, ei;
    bit          ef;
    logic [31:0] ecr, ecf;
    logic [15:0] ecd;
    bit          eerr;
  } vec_t;

  function automatic vec_t mk(bit nv, bit nr, logic [63:0] num, bit iv, logic [63:0] idx, bit ordy,
                              bit cl, bit ev, logic [63:0] en, logic [63:0] ei, bit ef,
                              logic [31:0] ecr, logic [31:0] ecf, logic [15:0] ecd, bit eerr);
    vec_t v;
    v.nv = nv; v.nr = nr; v.num = num; v.iv = iv; v.idx = idx; v.ordy = ordy; v.cl = cl;
    v.ev = ev; v.en = en; v.ei = ei; v.ef = ef; v.ecr = ecr; v.ecf = ecf; v.ecd = ecd; v.eerr = eerr;
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [63:0] last;
    logic [63:0] NEG1;
    NEG1 = '1;

    // nv nr num iv idx ordy clr | ev num idx fib cr cf cd err
    vt.push_back(mk(1,1, 5, 0,0,    1,0, 0,0,0,0,    0,0,0,0));
    vt.push_back(mk(0,0, 0, 0,0,    1,0, 0,0,0,0,    0,0,0,0));
    vt.push_back(mk(0,0, 0, 1,5,    1,0, 1,5,5,1,    1,1,0,0));
    vt.push_back(mk(0,0, 0, 0,0,    1,0, 0,0,0,0,    1,1,0,0));
    vt.push_back(mk(0,0, 0, 0,0,    1,1, 0,0,0,0,    0,0,0,0));
    vt.push_back(mk(1,1, 4, 0,0,    1,0, 0,0,0,0,    0,0,0,0));
    vt.push_back(mk(0,0, 0, 1,NEG1, 1,0, 1,4,NEG1,0, 1,0,0,0));
    vt.push_back(mk(0,0, 0, 0,0,    1,0, 0,0,0,0,    1,0,0,0));
    vt.push_back(mk(1,1, 0, 0,0,    0,0, 0,0,0,0,    1,0,0,0));
    vt.push_back(mk(1,1, 13,1,0,    0,0, 1,0,0,1,    2,1,0,0));
    vt.push_back(mk(0,0, 0, 1,7,    0,0, 1,0,0,1,    3,2,0,0));
    vt.push_back(mk(0,0, 0, 0,0,    1,0, 1,13,7,1,   3,2,0,0));
    vt.push_back(mk(0,0, 0, 0,0,    1,0, 0,0,0,0,    3,2,0,0));
    vt.push_back(mk(1,0, 99,0,0,    1,0, 0,0,0,0,    3,2,0,0));
    vt.push_back(mk(0,0, 0, 1,1,    1,0, 0,0,0,0,    3,2,0,1));

    do_reset();
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.out_number", out_number, 64'd0);
    chk("reset.out_index", out_index, 64'd0);
    chk("reset.out_is_fib", 64'(out_is_fib), 64'd0);
    chk("reset.cnt_results", 64'(cnt_results), 64'd0);
    chk("reset.cnt_drop", 64'(cnt_drop), 64'd0);
    chk("reset.err_orphan", 64'(err_orphan), 64'd0);

    for (int r = 0; r < vt.size(); r++) begin
      num_valid = vt[r].nv; num_ready = vt[r].nr; num_in = vt[r].num;
      index_valid = vt[r].iv; index = vt[r].idx; out_ready = vt[r].ordy; clr = vt[r].cl;
      tick();
      chk($sformatf("vec%0d.out_valid", r), 64'(out_valid), 64'(vt[r].ev));
      if (vt[r].ev) begin
        chk($sformatf("vec%0d.out_number", r), out_number, vt[r].en);
        chk($sformatf("vec%0d.out_index", r), out_index, vt[r].ei);
        chk($sformatf("vec%0d.out_is_fib", r), 64'(out_is_fib), 64'(vt[r].ef));
      end
      chk($sformatf("vec%0d.cnt_results", r), 64'(cnt_results), 64'(vt[r].ecr));
      chk($sformatf("vec%0d.cnt_fib", r), 64'(cnt_fib), 64'(vt[r].ecf));
      chk($sformatf("vec%0d.cnt_drop", r), 64'(cnt_drop), 64'(vt[r].ecd));
      chk($sformatf("vec%0d.err_orphan", r), 64'(err_orphan), 64'(vt[r].eerr));
    end

    // Fill past capacity with the consumer stalled, then push while full with a pop.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      req(64'(100 + k)); cycle("fill.req");
      strobe(64'(k));    cycle("fill.idx");
    end
    chk("full.cnt_results", 64'(cnt_results), 64'd8);
    chk("full.cnt_drop", 64'(cnt_drop), 64'd2);
    chk("full.head", out_number, 64'd100);
    req(64'd200); cycle("full.req");
    strobe(64'sd3); out_ready = 1; cycle("full.pushpop");
    chk("fullpop.cnt_results", 64'(cnt_results), 64'd9);
    chk("fullpop.cnt_drop", 64'(cnt_drop), 64'd2);
    chk("fullpop.head", out_number, 64'd101);
    idle(); out_ready = 1;
    n = 0; last = '0;
    for (int c = 0; c < 20 && out_valid; c++) begin
      last = out_number;
      cycle("drain");
      n++;
    end
    chk("drain.count", 64'(n), 64'd8);
    chk("drain.last", last, 64'd200);

    // Orphan strobe, then clear with data still queued and a clr-masked push.
    out_ready = 0;
    req(64'd50); cycle("orph.req");
    strobe(64'sd9); cycle("orph.pair");
    strobe(64'sd1); cycle("orph.strobe");
    chk("orph.err", 64'(err_orphan), 64'd1);
    chk("orph.cnt_results", 64'(cnt_results), 64'd10);
    idle(); clr = 1; cycle("clr");
    chk("clr.err", 64'(err_orphan), 64'd0);
    chk("clr.cnt_results", 64'(cnt_results), 64'd0);
    chk("clr.head", out_number, 64'd50);
    chk("clr.valid", 64'(out_valid), 64'd1);
    req(64'd60); cycle("clrpush.req");
    strobe(64'sd4); clr = 1; cycle("clrpush");
    chk("clrpush.cnt_results", 64'(cnt_results), 64'd0);
    idle(); out_ready = 1;
    cycle("clrpush.pop1");
    chk("clrpush.head", out_number, 64'd60);
    cycle("clrpush.pop2");

    // Asynchronous reset mid-operation with records queued and a request pending.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      req(64'(30 + k)); cycle("rst.req");
      strobe(64'(k));   cycle("rst.idx");
    end
    req(64'd77); cycle("rst.pend");
    idle();
    #2 rst = 1;
    #1;
    chk("arst.out_valid", 64'(out_valid), 64'd0);
    chk("arst.cnt_results", 64'(cnt_results), 64'd0);
    chk("arst.out_number", out_number, 64'd0);
    chk("arst.out_index", out_index, 64'd0);
    chk("arst.out_is_fib", 64'(out_is_fib), 64'd0);
    @(negedge clk);
    rst = 0;
    model_reset();
    strobe(64'sd2); cycle("arst.orphan");
    chk("arst.err", 64'(err_orphan), 64'd1);
    chk("arst.nopush", 64'(out_valid), 64'd0);
    req(64'd9); cycle("arst.req");
    strobe(64'sd2); cycle("arst.pair");
    chk("arst.head", out_number, 64'd9);
    chk("arst.cnt", 64'(cnt_results), 64'd1);

    // Random traffic against the queue model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      num_valid   = ($urandom_range(0, 1) == 1);
      num_ready   = ($urandom_range(0, 9) < 7);
      num_in      = 64'($urandom_range(0, 50));
      index_valid = ($urandom_range(0, 9) < 3);
      index       = ($urandom_range(0, 3) == 0) ? -64'sd1 : 64'($urandom_range(0, 90));
      out_ready   = ($urandom_range(0, 9) < (c % 400 < 200 ? 2 : 7));
      clr         = ($urandom_range(0, 99) == 0);
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
